unit_mul: RTL and testbench

UNIT_MUL -- requirements
Module: unit_MUL

---
 rtl/unit_mul.sv | 252 +++++++++++++++++++++++++
 tb/tb_unit_mul.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/unit_mul.sv
// Multiply unit with N_RS reservation stations, CDB snooping and one
// non-pipelined engine. Define UNIT_MUL_HI_EN to enable upper-word results.
module unit_mul #(
    parameter logic [7:0] TAG_BASE = 8'h40,
    parameter int         N_RS     = 3,
    parameter int         MUL_LAT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue,
    input  logic        signed_in,
    input  logic        hi_in,
    input  logic [7:0]  q1_in,
    input  logic [7:0]  q2_in,
    input  logic [31:0] v1_in,
    input  logic [31:0] v2_in,
    input  logic [40:0] cdb,
    output logic        all_busy,
    output logic [7:0]  issue_tag,
    output logic        cdb_request,
    output logic [39:0] cdb_out
);

    localparam int IW = (N_RS > 1) ? $clog2(N_RS) : 1;
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_CDB = 2'd2
    } state_t;

    function automatic logic [7:0] tag_of(input logic [IW-1:0] idx);
        return TAG_BASE + 8'(idx) + 8'd1;
    endfunction

    logic          busy_q [N_RS];
    logic          busy_d [N_RS];
    logic          disp_q [N_RS];
    logic          disp_d [N_RS];
    logic [7:0]    q1_q   [N_RS];
    logic [7:0]    q1_d   [N_RS];
    logic [7:0]    q2_q   [N_RS];
    logic [7:0]    q2_d   [N_RS];
    logic [31:0]   v1_q   [N_RS];
    logic [31:0]   v1_d   [N_RS];
    logic [31:0]   v2_q   [N_RS];
    logic [31:0]   v2_d   [N_RS];
`ifdef UNIT_MUL_HI_EN
    logic          sgn_q  [N_RS];
    logic          sgn_d  [N_RS];
    logic          hi_q   [N_RS];
    logic          hi_d   [N_RS];
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [39:0]   out_q, out_d;
    logic          req_q, req_d;

    logic          cdb_vld_s;
    logic [7:0]    cdb_tag_s;
    logic [31:0]   cdb_val_s;
    logic          free_found_s, rdy_found_s;
    logic [IW-1:0] free_idx_s, rdy_idx_s;
    logic [31:0]   result_s;
    logic          accept_s, grant_s;

    assign cdb_vld_s = cdb[40];
    assign cdb_tag_s = cdb[39:32];
    assign cdb_val_s = cdb[31:0];

    // Lowest-index free station and lowest-index dispatchable station.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        rdy_found_s  = 1'b0;
        rdy_idx_s    = '0;
        for (int i = N_RS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = IW'(i);
            end else begin
                free_found_s = free_found_s;
            end
            if (busy_q[i] && !disp_q[i] && (q1_q[i] == 8'h00) && (q2_q[i] == 8'h00)) begin
                rdy_found_s = 1'b1;
                rdy_idx_s   = IW'(i);
            end else begin
                rdy_found_s = rdy_found_s;
            end
        end
    end

    assign all_busy    = !free_found_s;
    assign issue_tag   = free_found_s ? tag_of(free_idx_s) : 8'h00;
    assign accept_s    = issue && free_found_s;
    assign grant_s     = cdb_vld_s && (cdb_tag_s == tag_of(sel_q));
    assign cdb_request = req_q;
    assign cdb_out     = out_q;

`ifdef UNIT_MUL_HI_EN
    logic [63:0] op1_s, op2_s, prod_s;

    // Full 64-bit product of the selected station, word chosen by its hi bit.
    always_comb begin
        op1_s    = sgn_q[sel_q] ? {{32{v1_q[sel_q][31]}}, v1_q[sel_q]} : {32'h0, v1_q[sel_q]};
        op2_s    = sgn_q[sel_q] ? {{32{v2_q[sel_q][31]}}, v2_q[sel_q]} : {32'h0, v2_q[sel_q]};
        prod_s   = op1_s * op2_s;
        result_s = hi_q[sel_q] ? prod_s[63:32] : prod_s[31:0];
    end
`else
    // Low word is identical for signed and unsigned operands.
    always_comb begin
        result_s = v1_q[sel_q] * v2_q[sel_q];
    end
`endif

    // Next-state: CDB snoop, issue capture with forwarding, engine FSM.
    always_comb begin
        busy_d  = busy_q;
        disp_d  = disp_q;
        q1_d    = q1_q;
        q2_d    = q2_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
`ifdef UNIT_MUL_HI_EN
        sgn_d   = sgn_q;
        hi_d    = hi_q;
`endif
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        out_d   = out_q;

        for (int i = 0; i < N_RS; i++) begin
            if (busy_q[i] && cdb_vld_s && (q1_q[i] != 8'h00) && (q1_q[i] == cdb_tag_s)) begin
                q1_d[i] = 8'h00;
                v1_d[i] = cdb_val_s;
            end else begin
                q1_d[i] = q1_q[i];
            end
            if (busy_q[i] && cdb_vld_s && (q2_q[i] != 8'h00) && (q2_q[i] == cdb_tag_s)) begin
                q2_d[i] = 8'h00;
                v2_d[i] = cdb_val_s;
            end else begin
                q2_d[i] = q2_q[i];
            end
        end

        if (accept_s) begin
            busy_d[free_idx_s] = 1'b1;
            disp_d[free_idx_s] = 1'b0;
`ifdef UNIT_MUL_HI_EN
            sgn_d[free_idx_s]  = signed_in;
            hi_d[free_idx_s]   = hi_in;
`endif
            if (cdb_vld_s && (q1_in != 8'h00) && (q1_in == cdb_tag_s)) begin
                q1_d[free_idx_s] = 8'h00;
                v1_d[free_idx_s] = cdb_val_s;
            end else begin
                q1_d[free_idx_s] = q1_in;
                v1_d[free_idx_s] = v1_in;
            end
            if (cdb_vld_s && (q2_in != 8'h00) && (q2_in == cdb_tag_s)) begin
                q2_d[free_idx_s] = 8'h00;
                v2_d[free_idx_s] = cdb_val_s;
            end else begin
                q2_d[free_idx_s] = q2_in;
                v2_d[free_idx_s] = v2_in;
            end
        end else begin
            busy_d = busy_d;
        end

        case (state_q)
            IDLE: begin
                if (rdy_found_s) begin
                    disp_d[rdy_idx_s] = 1'b1;
                    sel_d             = rdy_idx_s;
                    cnt_d             = CW'(MUL_LAT - 1);
                    state_d           = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    out_d   = {tag_of(sel_q), result_s};
                    state_d = WAIT_CDB;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_CDB: begin
                if (grant_s) begin
                    busy_d[sel_q] = 1'b0;
                    disp_d[sel_q] = 1'b0;
                    state_d       = IDLE;
                end else begin
                    state_d = WAIT_CDB;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d = (state_d == WAIT_CDB);
    end

    // State registers; reset drops any in-flight result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_RS; i++) begin
                busy_q[i] <= 1'b0;
                disp_q[i] <= 1'b0;
                q1_q[i]   <= 8'h00;
                q2_q[i]   <= 8'h00;
                v1_q[i]   <= 32'h0;
                v2_q[i]   <= 32'h0;
`ifdef UNIT_MUL_HI_EN
                sgn_q[i]  <= 1'b0;
                hi_q[i]   <= 1'b0;
`endif
            end
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            out_q   <= 40'h0;
            req_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            disp_q  <= disp_d;
            q1_q    <= q1_d;
            q2_q    <= q2_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
`ifdef UNIT_MUL_HI_EN
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
`endif
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            req_q   <= req_d;
        end
    end

endmodule

// File: tb/tb_unit_mul.sv
// Directed bench for unit_mul: stimulus pushes expected broadcasts into a
// queue, a negedge monitor pops and compares each new CDB request.
module tb_unit_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue;
    logic        signed_in;
    logic        hi_in;
    logic [7:0]  q1_in, q2_in;
    logic [31:0] v1_in, v2_in;
    logic [40:0] cdb;
    logic        all_busy;
    logic [7:0]  issue_tag;
    logic        cdb_request;
    logic [39:0] cdb_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [39:0] exp_q [$];
    logic        prev_req = 1'b0;

`ifdef UNIT_MUL_HI_EN
    localparam logic [31:0] EXP_S_HI = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_U_HI = 32'h0000_0002;
`else
    localparam logic [31:0] EXP_S_HI = 32'hFFFF_FFFA;
    localparam logic [31:0] EXP_U_HI = 32'hFFFF_FFFA;
`endif

    unit_mul dut (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue),
        .signed_in   (signed_in),
        .hi_in       (hi_in),
        .q1_in       (q1_in),
        .q2_in       (q2_in),
        .v1_in       (v1_in),
        .v2_in       (v2_in),
        .cdb         (cdb),
        .all_busy    (all_busy),
        .issue_tag   (issue_tag),
        .cdb_request (cdb_request),
        .cdb_out     (cdb_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic sgn, input logic hi, input logic [7:0] q1, input logic [31:0] v1,
                            input logic [7:0] q2, input logic [31:0] v2, input logic [7:0] exp_tag,
                            input string name);
        issue     = 1'b1;
        signed_in = sgn;
        hi_in     = hi;
        q1_in     = q1;
        v1_in     = v1;
        q2_in     = q2;
        v2_in     = v2;
        #1;
        check(name, 64'(issue_tag), 64'(exp_tag));
        tick();
        issue = 1'b0;
    endtask

    task automatic wait_req(input int exp_n, input string name);
        int n = 0;
        while (!cdb_request && n < 50) begin
            tick();
            n++;
        end
        check(name, 64'(n), 64'(exp_n));
    endtask

    task automatic grant(input logic [7:0] tag);
        cdb = {1'b1, tag, 32'hDEAD_BEEF};
        tick();
        cdb = 41'h0;
    endtask

    // Scoreboard monitor: each rising cdb_request must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            prev_req <= 1'b0;
        end else begin
            if (cdb_request && !prev_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_broadcast", 64'(cdb_out), 64'h0);
                end else begin
                    check("cdb_out", 64'(cdb_out), 64'(exp_q.pop_front()));
                end
            end
            prev_req <= cdb_request;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; issue = 1'b0; signed_in = 1'b0; hi_in = 1'b0;
        q1_in = 8'h00; q2_in = 8'h00; v1_in = 32'h0; v2_in = 32'h0; cdb = 41'h0;
        repeat (3) tick();
        check("rst_req", 64'(cdb_request), 64'h0);
        check("rst_busy", 64'(all_busy), 64'h0);
        check("rst_tag", 64'(issue_tag), 64'h41);
        check("rst_out", 64'(cdb_out), 64'h0);
        rst = 1'b1;
        tick();

        // 6 * 7 unsigned, request four cycles after dispatch
        exp_q.push_back(40'h41_0000_002A);
        do_issue(1'b0, 1'b0, 8'h00, 32'd6, 8'h00, 32'd7, 8'h41, "t1_tag");
        wait_req(5, "t1_latency");
        grant(8'h41);
        check("t1_req_drop", 64'(cdb_request), 64'h0);

        // operand arrives on CDB two cycles after issue
        exp_q.push_back(40'h41_0000_000F);
        do_issue(1'b0, 1'b0, 8'h21, 32'h1111_1111, 8'h00, 32'd3, 8'h41, "t2_tag");
        tick();
        cdb = 41'h1_21_0000_0005;
        tick();
        cdb = 41'h0;
        wait_req(5, "t2_latency");
        grant(8'h41);

        // signed / unsigned, upper and lower words
        exp_q.push_back({8'h41, EXP_S_HI});
        do_issue(1'b1, 1'b1, 8'h00, 32'hFFFF_FFFE, 8'h00, 32'd3, 8'h41, "t3a_tag");
        wait_req(5, "t3a_latency");
        grant(8'h41);
        exp_q.push_back(40'h41_FFFF_FFFA);
        do_issue(1'b1, 1'b0, 8'h00, 32'hFFFF_FFFE, 8'h00, 32'd3, 8'h41, "t3b_tag");
        wait_req(5, "t3b_latency");
        grant(8'h41);
        exp_q.push_back({8'h41, EXP_U_HI});
        do_issue(1'b0, 1'b1, 8'h00, 32'hFFFF_FFFE, 8'h00, 32'd3, 8'h41, "t3c_tag");
        wait_req(5, "t3c_latency");
        grant(8'h41);

        // fill all stations, ignored fourth issue, held request, grants
        exp_q.push_back(40'h41_0000_0006);
        exp_q.push_back(40'h42_0000_0014);
        exp_q.push_back(40'h43_0001_2340);
        do_issue(1'b0, 1'b0, 8'h00, 32'd2, 8'h00, 32'd3, 8'h41, "t4_tag1");
        do_issue(1'b0, 1'b0, 8'h00, 32'd4, 8'h00, 32'd5, 8'h42, "t4_tag2");
        do_issue(1'b0, 1'b0, 8'h00, 32'h1234, 8'h00, 32'h10, 8'h43, "t4_tag3");
        check("t4_all_busy", 64'(all_busy), 64'h1);
        do_issue(1'b0, 1'b0, 8'h00, 32'd9, 8'h00, 32'd9, 8'h00, "t4_tag_full");
        check("t4_still_busy", 64'(all_busy), 64'h1);
        wait_req(2, "t4_latency1");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold", {23'h0, cdb_request, cdb_out}, {23'h0, 1'b1, 40'h41_0000_0006});
        end
        grant(8'h41);
        check("t4_free_busy", 64'(all_busy), 64'h0);
        check("t4_free_tag", 64'(issue_tag), 64'h41);
        wait_req(5, "t4_latency2");
        grant(8'h42);
        wait_req(5, "t4_latency3");
        grant(8'h43);

        // same-cycle forwarding on issue
        exp_q.push_back(40'h41_0000_003F);
        cdb = 41'h1_30_0000_0007;
        do_issue(1'b0, 1'b0, 8'h30, 32'h5555_5555, 8'h00, 32'd9, 8'h41, "t5_tag");
        cdb = 41'h0;
        wait_req(5, "t5_latency");
        grant(8'h41);

        // reset while engine is in EXEC with all stations busy
        do_issue(1'b0, 1'b0, 8'h00, 32'd2, 8'h00, 32'd2, 8'h41, "t6_tag1");
        do_issue(1'b0, 1'b0, 8'h00, 32'd3, 8'h00, 32'd3, 8'h42, "t6_tag2");
        do_issue(1'b0, 1'b0, 8'h00, 32'd4, 8'h00, 32'd4, 8'h43, "t6_tag3");
        check("t6_pre_busy", 64'(all_busy), 64'h1);
        exp_q.delete();
        #2;
        rst = 1'b0;
        #1;
        check("t6_req", 64'(cdb_request), 64'h0);
        check("t6_busy", 64'(all_busy), 64'h0);
        check("t6_tag", 64'(issue_tag), 64'h41);
        check("t6_out", 64'(cdb_out), 64'h0);
        tick();
        tick();
        rst = 1'b1;
        repeat (12) tick();
        check("t6_idle_req", 64'(cdb_request), 64'h0);

        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
